rr_mux_4_1_stage: RTL

RR_MUX_4_1_STAGE -- requirements
Module: rr_mux_4_1_stage

---
 rtl/rr_mux_4_1_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/rr_mux_4_1_stage.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_4_1_stage
// Purpose  : Four-channel round-robin arbiter feeding a 4:1 data select into
//            a one-entry registered output stage with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_4_1_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  // Reset value of the last-grant pointer makes channel 0 the first winner.
  localparam logic [1:0] c_LAST_RESET = 2'd3;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_sel_q,   out_sel_d;
  logic [1:0]       last_q,      last_d;

  logic             w_can_accept;
  logic             w_grant_found;
  logic [1:0]       w_grant_idx;
  logic [1:0]       w_cand;
  logic [3:0]       w_grant_oh;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_take;

  assign w_can_accept = !out_valid_q || out_ready;

  // Search last+1, last+2, last+3, last; the 2-bit add wraps modulo 4.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = last_q;
    w_cand        = last_q;
    for (int k = 1; k <= 4; k++) begin
      w_cand = last_q + k[1:0];
      if (!w_grant_found && in_valid[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  assign w_grant_oh = 4'b0001 << w_grant_idx;

  always_comb begin
    in_ready = 4'b0000;
    if (!rst && w_can_accept && w_grant_found) begin
      in_ready = w_grant_oh;
    end
  end

  assign w_take = |(in_valid & in_ready);

  // Only the granted channel's data is routed, keeping X on idle lanes out.
  always_comb begin
    w_sel_data = d0;
    case (w_grant_idx)
      2'd0:    w_sel_data = d0;
      2'd1:    w_sel_data = d1;
      2'd2:    w_sel_data = d2;
      2'd3:    w_sel_data = d3;
      default: w_sel_data = d0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (w_take) begin
      out_valid_d = 1'b1;
      out_data_d  = w_sel_data;
      out_sel_d   = w_grant_idx;
      last_d      = w_grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      last_q      <= c_LAST_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
`default_nettype wire
